// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 4) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider producing one quotient bit per clock.
// Define DIV_SIGNED_EN to treat operands as two's complement (sign fix-up around an unsigned core).
module seq_divider #(parameter int WIDTH = 4) (
  input  logic clk,
  input  logic rst,
  seq_divider_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           r_state, w_state;
  logic [CW-1:0]    r_count, w_count;
  logic [WIDTH-1:0] r_rem, w_rem;
  logic [WIDTH-1:0] r_q, w_q;
  logic [WIDTH-1:0] r_d, w_d;
  logic [WIDTH-1:0] r_quotient, w_quotient;
  logic [WIDTH-1:0] r_remainder, w_remainder;
  logic             r_dbz, w_dbz;
  logic             r_done, w_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_qIter, w_remIter;
  logic [WIDTH-1:0] w_dividendMag, w_divisorMag;
  logic [WIDTH-1:0] w_qFinal, w_remFinal;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && io.start && (io.divisor != '0);

  // The extra top bit of the shifted remainder keeps the compare from wrapping.
  assign w_shift   = {r_rem, r_q[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_d});
  assign w_diff    = w_shift[WIDTH-1:0] - r_d;
  assign w_remIter = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_qIter   = {r_q[WIDTH-2:0], w_ge};

`ifdef DIV_SIGNED_EN
  logic r_negQ, r_negR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
    end else if (w_accept) begin
      r_negQ <= io.dividend[WIDTH-1] ^ io.divisor[WIDTH-1];
      r_negR <= io.dividend[WIDTH-1];
    end
  end

  // Most-negative / -1 wraps back to most-negative through the negation.
  assign w_dividendMag = io.dividend[WIDTH-1] ? -io.dividend : io.dividend;
  assign w_divisorMag  = io.divisor[WIDTH-1]  ? -io.divisor  : io.divisor;
  assign w_qFinal      = r_negQ ? -w_qIter   : w_qIter;
  assign w_remFinal    = r_negR ? -w_remIter : w_remIter;
`else
  assign w_dividendMag = io.dividend;
  assign w_divisorMag  = io.divisor;
  assign w_qFinal      = w_qIter;
  assign w_remFinal    = w_remIter;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_rem       <= w_rem;
      r_q         <= w_q;
      r_d         <= w_d;
      r_quotient  <= w_quotient;
      r_remainder <= w_remainder;
      r_dbz       <= w_dbz;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_rem       = r_rem;
    w_q         = r_q;
    w_d         = r_d;
    w_quotient  = r_quotient;
    w_remainder = r_remainder;
    w_dbz       = r_dbz;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (io.start) begin
          if (io.divisor == '0) begin
            w_quotient  = '1;
            w_remainder = io.dividend;
            w_dbz       = 1'b1;
            w_done      = 1'b1;
          end else begin
            w_state = CALC;
            w_rem   = '0;
            w_q     = w_dividendMag;
            w_d     = w_divisorMag;
            w_count = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        w_rem   = w_remIter;
        w_q     = w_qIter;
        w_count = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state     = IDLE;
          w_quotient  = w_qFinal;
          w_remainder = w_remFinal;
          w_dbz       = 1'b0;
          w_done      = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign io.busy        = (r_state == CALC);
  assign io.done        = r_done;
  assign io.quotient    = r_quotient;
  assign io.remainder   = r_remainder;
  assign io.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes model results, a negedge monitor pops and compares.
module tb_seq_divider;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edgeCount = 0;
  int   nChecks = 0;
  int   nFails = 0;
  exp_t sbq[$];
  exp_t monE;
  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;
  logic         lastDbz = 1'b0;

  seq_divider_if #(.WIDTH(W)) io ();

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  // Reference results straight from integer division semantics.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
    exp_t e;
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      e.q     = '1;
      e.r     = a;
      e.dbz   = 1'b1;
      e.cycle = e0;
    end else begin
`ifdef DIV_SIGNED_EN
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.dbz   = 1'b0;
      e.cycle = e0 + W;
    end
    return e;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (io.busy && n < 2 * W + 10) begin
      stepCycle();
      n++;
    end
    if (io.busy) checkOutput("idle wait", io.busy, 0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbq.size() > 0 && n < 4 * W + 10) begin
      stepCycle();
      n++;
    end
    if (sbq.size() > 0) checkOutput("scoreboard drained", sbq.size(), 0);
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    waitIdle();
    io.start    = 1'b1;
    io.dividend = a;
    io.divisor  = b;
    stepCycle();
    sbq.push_back(model(a, b, edgeCount));
    if (!hold) io.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      lastQ   = '0;
      lastR   = '0;
      lastDbz = 1'b0;
    end else begin
      if (sbq.size() > 0 && edgeCount > sbq[0].cycle) begin
        checkOutput("done by edge", edgeCount, sbq[0].cycle);
        void'(sbq.pop_front());
      end
      if (io.done) begin
        checkOutput("busy during done", io.busy, 0);
        if (sbq.size() == 0) begin
          checkOutput("pending ops at done", sbq.size(), 1);
        end else begin
          monE = sbq.pop_front();
          checkOutput("done edge", edgeCount, monE.cycle);
          checkOutput("quotient", io.quotient, monE.q);
          checkOutput("remainder", io.remainder, monE.r);
          checkOutput("div_by_zero", io.div_by_zero, monE.dbz);
          lastQ   = monE.q;
          lastR   = monE.r;
          lastDbz = monE.dbz;
        end
      end else begin
        checkOutput("held quotient", io.quotient, lastQ);
        checkOutput("held remainder", io.remainder, lastR);
        checkOutput("held div_by_zero", io.div_by_zero, lastDbz);
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    io.start    = 1'b0;
    io.dividend = '0;
    io.divisor  = '0;
    rst         = 1'b1;
    repeat (2) stepCycle();
    checkOutput("reset busy", io.busy, 0);
    checkOutput("reset done", io.done, 0);
    checkOutput("reset quotient", io.quotient, 0);
    checkOutput("reset remainder", io.remainder, 0);
    checkOutput("reset div_by_zero", io.div_by_zero, 0);
    rst = 1'b0;

    applyStimulus(4'd13, 4'd3, 1'b0);
    applyStimulus(4'd15, 4'd0, 1'b0);

    // Start stays high through the busy window with new operands presented.
    applyStimulus(4'd7, 4'd9, 1'b1);
    io.dividend = 4'd2;
    io.divisor  = 4'd1;
    applyStimulus(4'd2, 4'd1, 1'b0);

    // Abort mid-calculation: no done pulse, outputs back to zero.
    waitDrain();
    waitIdle();
    io.start    = 1'b1;
    io.dividend = 4'd13;
    io.divisor  = 4'd3;
    stepCycle();
    io.start = 1'b0;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort busy", io.busy, 0);
    checkOutput("abort done", io.done, 0);
    checkOutput("abort quotient", io.quotient, 0);
    checkOutput("abort remainder", io.remainder, 0);
    checkOutput("abort div_by_zero", io.div_by_zero, 0);
    repeat (W + 2) stepCycle();
    applyStimulus(4'd6, 4'd2, 1'b0);

`ifdef DIV_SIGNED_EN
    applyStimulus(4'b1001, 4'd2, 1'b0);
    applyStimulus(4'b1000, 4'b1111, 1'b0);
    applyStimulus(4'd5, 4'b1101, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(W'(i), W'(j), 1'b0);
      end
    end

    repeat (150) begin
      a = W'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 15));
      applyStimulus(a, b, 1'b0);
      repeat ($urandom_range(0, 2)) stepCycle();
    end

    waitDrain();
    repeat (2) stepCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
